// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the N-way request/grant arbiter.
package arbiter_pkg;

  // Largest supported requester count; sizes the index helper below.
  localparam int MAX_N = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // One-hot (or zero) vector to bit index. OR-ing the indices of the set
  // bits is exact for one-hot input and yields 0 for an empty vector.
  function automatic logic [3:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arbiter_n_rr_pick.sv
// Combinational masked priority picker. Searches the unmasked requests
// upward from a start index (round-robin) or from index 0 (fixed), with
// wrap-around, and returns the first hit as one-hot plus its index.
module rr_pick
  import arbiter_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   mask,
  input  logic [IDW-1:0] start,
  input  logic           mode,
  output logic [N-1:0]   win_oh,
  output logic [IDW-1:0] win_idx,
  output logic           win_any
);

  // Wrap limit held one bit wider than an index so start+k cannot overflow.
  localparam logic [IDW:0] NW = (IDW+1)'(N);

  logic [N-1:0]     cand;
  logic [MAX_N-1:0] win_ext;

  assign cand    = req & ~mask;
  assign win_any = |cand;

  // Walk N candidate positions from the start point; first request seen wins.
  always_comb begin
    logic [IDW:0] pos;
    logic         found;
    pos    = '0;
    found  = 1'b0;
    win_oh = '0;
    for (int k = 0; k < N; k++) begin
      pos = (mode ? {1'b0, start} : '0) + (IDW+1)'(k);
      if (pos >= NW) pos = pos - NW;
      if (!found && cand[pos[IDW-1:0]]) begin
        win_oh[pos[IDW-1:0]] = 1'b1;
        found                = 1'b1;
      end
    end
  end

  assign win_ext = MAX_N'(win_oh);
  assign win_idx = IDW'(onehot_to_idx(win_ext));

endmodule

// File: rtl/arbiter_n.sv
// N-way synchronous request/grant arbiter with run-time fixed/round-robin
// priority and a hold limit that forces handover when others are waiting.
// Outputs are registered; one cycle from req to gnt, zero-bubble handover.
module arbiter_n
  import arbiter_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int HOLD_MAX = 8,
  localparam int IDW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic           mode,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id
);

  // Counter only needs to reach HOLD_MAX-1; keep at least one bit when unlimited.
  localparam int             HCW      = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [IDW-1:0] LAST_IDX = IDW'(N - 1);

  state_e         state;
  logic [IDW-1:0] last_owner;
  logic [IDW-1:0] rr_start;
  logic [HCW-1:0] hold_cnt;

  logic [N-1:0]   win_oh;
  logic [IDW-1:0] win_idx;
  logic           win_any;
  logic           owner_req;
  logic           hold_ok;

  // Round-robin search begins just past the most recent owner, wrapping at N.
  assign rr_start  = (last_owner == LAST_IDX) ? '0 : last_owner + IDW'(1);

  // gnt_id doubles as the owner register while a grant is active.
  assign owner_req = req[gnt_id];

  // The owner may keep the grant while under the hold limit (or unlimited).
  assign hold_ok   = (HOLD_MAX == 0) || (int'(hold_cnt) < HOLD_MAX - 1);

  // Masking with the current grant excludes the owner during GRANT and is a
  // no-op in IDLE, where gnt is zero, so one picker serves every arbitration.
  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req     (req),
    .mask    (gnt),
    .start   (rr_start),
    .mode    (mode),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_any (win_any)
  );

  // Grant FSM: owner, last owner, hold counter and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= '0;
      gnt_valid  <= 1'b0;
      gnt_id     <= '0;
      hold_cnt   <= '0;
      last_owner <= LAST_IDX;
    end else begin
      case (state)
        IDLE: begin
          if (win_any) begin
            state      <= GRANT;
            gnt        <= win_oh;
            gnt_valid  <= 1'b1;
            gnt_id     <= win_idx;
            last_owner <= win_idx;
            hold_cnt   <= '0;
          end
        end
        GRANT: begin
          if (owner_req && hold_ok) begin
            // Unlimited mode never counts, so the counter cannot wrap.
            if (HOLD_MAX != 0) hold_cnt <= hold_cnt + HCW'(1);
          end else if (win_any) begin
            // Owner released or hit its limit with others waiting: hand over
            // on this edge with no idle cycle between owners.
            gnt        <= win_oh;
            gnt_id     <= win_idx;
            last_owner <= win_idx;
            hold_cnt   <= '0;
          end else if (owner_req) begin
            // Limit reached but nobody else wants it: restart the window.
            hold_cnt <= '0;
          end else begin
            // gnt_id keeps the last owner while idle.
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/arbiter_n.md
# arbiter_n

N-way synchronous request/grant arbiter, the parametrised successor to the two-port fixed-priority arbiter FSM. It accepts N request lines and issues at most one registered one-hot grant. The priority mode (fixed or round-robin) is selectable at run time, and a hold limit prevents starvation. It sits between shared-resource clients (bus masters, memory ports) and the resource's select logic.

## Interface
- N, 4: number of requesters, 1..16.
- HOLD_MAX, 8: maximum consecutive grant cycles while others wait; 0 = unlimited.
- IDW, $clog2(N) (min 1): width of gnt_id; derived, not overridden.
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- req  in  N  request vector; bit i = requester i.
- mode  in  1  0 = fixed priority (lowest index wins), 1 = round-robin.
- gnt  out  N  registered one-hot grant; all-zero when idle.
- gnt_valid  out  1  high when any gnt bit is set.
- gnt_id  out  IDW  index of the granted requester; holds its last value when idle.

## Operation
- States: IDLE, GRANT.
- IDLE: if req == 0, stay. Otherwise pick the winner, go to GRANT, set the owner, clear hold_cnt.
- GRANT while req[owner] = 1:
  - If HOLD_MAX = 0 or hold_cnt < HOLD_MAX-1: keep the grant and increment hold_cnt.
  - Otherwise (limit reached): if any other req is set, switch directly to the winner among the others (owner masked out). If no other req is set, keep the owner and clear hold_cnt.
- GRANT with req[owner] = 0: if any other req is set, switch directly to the new winner (no idle bubble). Otherwise go to IDLE and clear gnt.
- Winner selection:
  - Fixed mode: lowest set index.
  - Round-robin mode: first set index searching upward from last_owner+1, wrapping modulo N.
- last_owner updates on every new grant, in both modes.
- mode is sampled only at arbitration points. A change during GRANT does not disturb the current owner.
- N = 1: the grant follows req with one-cycle latency; the hold limit never forces release.
- Invariants: gnt is always one-hot or zero; gnt_valid == |gnt; gnt[gnt_id] == 1 whenever gnt_valid is high.

## Timing
- req sampled at edge t drives gnt at edge t+1 (one-cycle latency); no combinational path from req to the outputs.
- Handover between owners takes zero idle cycles: the old gnt bit falls and the new one rises on the same edge.
- The grant is removed one cycle after the owner drops req.
- Reset values: state = IDLE, gnt = 0, gnt_valid = 0, gnt_id = 0, hold_cnt = 0, last_owner = N-1 (so req[0] wins the first round-robin arbitration).
- Reset mid-grant: the grant is removed at that edge; the first arbitration after reset deasserts follows the reset values above.
- hold_cnt width is $clog2(HOLD_MAX+1) and it never wraps. A forced switch occurs after exactly HOLD_MAX grant cycles.

## Structure
- Shared package arbiter_pkg holds the state enum (IDLE, GRANT) and a function for the one-hot-to-index conversion.
- One sub-module, rr_pick: combinational masked priority picker. Inputs: req, mask, start index, mode. Outputs: one-hot winner and its index. It is instantiated once.
- The top level holds the FSM, owner/last_owner registers, hold counter and output registers.

## Test plan
- Reset, then req = 4'b0110 in fixed mode: gnt = 4'b0010 and gnt_id = 1 one cycle later. Drop req[1]: gnt = 4'b0100 on the next edge with no gap.
- Round-robin mode, req = 4'b1111 held, HOLD_MAX = 1: gnt rotates 0001→0010→0100→1000→0001, one step per cycle.
- HOLD_MAX = 8, req[2] held with req[0] also set: gnt[2] is held for exactly 8 cycles, then gnt = 4'b0001. With req[2] alone, gnt[2] stays high indefinitely.
- Toggle mode mid-grant: the owner is unchanged, and the next arbitration uses the new mode.
- Assert reset during GRANT: gnt = 0, gnt_valid = 0 after that edge. With all req held at release, round-robin grants req[0] first.
- Random req/mode for 10k cycles: checker confirms gnt is one-hot or zero, gnt_valid/gnt_id are consistent, and in round-robin mode no held requester waits more than (N-1)·HOLD_MAX cycles.
